// File: rtl/data_mem_responder.sv
// Word-organised 32-bit data memory answering load/store requests over a req/ready handshake.
// Latency: req accepted at edge t -> one-cycle ready pulse in cycle t+1+WAIT_CYCLES.
// Backpressure: none internally; the initiator holds req until ready, then drops it or re-requests.
module data_mem_responder #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [3:0]  wstrb,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        error,
   output logic        busy
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                state, next_state;
   logic [CW-1:0]         cnt, cnt_nxt;
   logic                  l_we;
   logic [3:0]            l_wstrb;
   logic [31:0]           l_addr;
   logic [31:0]           l_wdata;
   logic [31:0]           rdata_q;
   logic [31:0]           mem [0:DEPTH-1];

   // In IDLE the access being accepted is still on the inputs; afterwards only the latched copy counts.
   logic [31:0]           sel_addr;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_word;
   logic [ADDR_WIDTH-1:0] l_word;
   logic                  lat_err;

   function automatic logic addr_err(input logic [31:0] a);
      return (a[1:0] != 2'b00) | (a[31:ADDR_WIDTH+2] != '0);
   endfunction

   assign sel_addr = (state == S_IDLE) ? addr : l_addr;
   assign sel_we   = (state == S_IDLE) ? we   : l_we;
   assign sel_word = sel_addr[ADDR_WIDTH+1:2];
   assign l_word   = l_addr[ADDR_WIDTH+1:2];
   assign lat_err  = addr_err(l_addr);

   // State register and wait counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= next_state;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state logic, wait-state countdown and response outputs.
   always_comb begin
      next_state = state;
      cnt_nxt    = cnt;
      ready      = 1'b0;
      error      = 1'b0;
      rdata      = '0;
      busy       = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (req) begin
               if (WAIT_CYCLES == 0) begin
                  next_state = S_RESP;
               end else begin
                  next_state = S_WAIT;
                  cnt_nxt    = CNT_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (cnt == '0) next_state = S_RESP;
            else           cnt_nxt    = cnt - CW'(1);
         end
         S_RESP: begin
            next_state = S_IDLE;
            ready      = 1'b1;
            error      = lat_err;
            rdata      = rdata_q;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Capture the request on acceptance so later input changes cannot disturb it.
   always_ff @(posedge clk) begin
      if (reset) begin
         l_we    <= 1'b0;
         l_wstrb <= '0;
         l_addr  <= '0;
         l_wdata <= '0;
      end else if (state == S_IDLE && req) begin
         l_we    <= we;
         l_wstrb <= wstrb;
         l_addr  <= addr;
         l_wdata <= wdata;
      end
   end

   // Load data is fetched on the edge entering RESP; stores and rejected accesses return zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= '0;
      end else if (next_state == S_RESP) begin
         rdata_q <= (sel_we || addr_err(sel_addr)) ? '0 : mem[sel_word];
      end
   end

   // Byte-enabled store commits on the edge ending RESP; reset on that edge cancels it.
   always_ff @(posedge clk) begin
      if (!reset && state == S_RESP && l_we && !lat_err) begin
         for (int i = 0; i < 4; i++) begin
            if (l_wstrb[i]) mem[l_word][8*i +: 8] <= l_wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: instance A has two wait states, instance B none.
// Stimulus pushes expected responses; per-instance monitors pop and compare on each ready pulse.
// Expected values and response cycles are hand-derived from the access sequence.
module tb_data_mem_responder;

   localparam int WA = 2;
   localparam int WB = 0;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   logic        reset_a, req_a, we_a, ready_a, error_a, busy_a;
   logic [3:0]  wstrb_a;
   logic [31:0] addr_a, wdata_a, rdata_a;
   logic        reset_b, req_b, we_b, ready_b, error_b, busy_b;
   logic [3:0]  wstrb_b;
   logic [31:0] addr_b, wdata_b, rdata_b;

   exp_t q_a[$];
   exp_t q_b[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(WA)) dut_a (
      .clk(clk), .reset(reset_a), .req(req_a), .we(we_a), .wstrb(wstrb_a),
      .addr(addr_a), .wdata(wdata_a), .rdata(rdata_a), .ready(ready_a),
      .error(error_a), .busy(busy_a)
   );

   data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(WB)) dut_b (
      .clk(clk), .reset(reset_b), .req(req_b), .we(we_b), .wstrb(wstrb_b),
      .addr(addr_b), .wdata(wdata_b), .rdata(rdata_b), .ready(ready_b),
      .error(error_b), .busy(busy_b)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Monitor for instance A.
   always @(negedge clk) begin
      exp_t e;
      if (ready_a === 1'b1) begin
         if (q_a.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL a_unexpected_ready actual=ready@%0d required=none", cyc);
         end else begin
            e = q_a.pop_front();
            chk("a_error", {31'd0, error_a}, {31'd0, e.err});
            chk("a_rdata", rdata_a, e.rdata);
            chk("a_cycle", cyc, e.cyc);
         end
      end
   end

   // Monitor for instance B.
   always @(negedge clk) begin
      exp_t e;
      if (ready_b === 1'b1) begin
         if (q_b.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL b_unexpected_ready actual=ready@%0d required=none", cyc);
         end else begin
            e = q_b.pop_front();
            chk("b_error", {31'd0, error_b}, {31'd0, e.err});
            chk("b_rdata", rdata_b, e.rdata);
            chk("b_cycle", cyc, e.cyc);
         end
      end
   end

   // Single access on instance A; called just after a rising edge with A idle.
   task automatic acc_a(input logic w, input logic [3:0] s, input logic [31:0] ad,
                        input logic [31:0] wd, input logic e, input logic [31:0] rd);
      req_a = 1'b1; we_a = w; wstrb_a = s; addr_a = ad; wdata_a = wd;
      @(posedge clk); #1;
      q_a.push_back('{e, rd, cyc + WA});
      req_a = 1'b0;
      repeat (WA + 2) @(posedge clk);
      #1;
   endtask

   task automatic acc_b(input logic w, input logic [3:0] s, input logic [31:0] ad,
                        input logic [31:0] wd, input logic e, input logic [31:0] rd);
      req_b = 1'b1; we_b = w; wstrb_b = s; addr_b = ad; wdata_b = wd;
      @(posedge clk); #1;
      q_b.push_back('{e, rd, cyc + WB});
      req_b = 1'b0;
      repeat (WB + 2) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int a0;
      int nbusy;
      reset_a = 1'b1; req_a = 1'b0; we_a = 1'b0; wstrb_a = '0; addr_a = '0; wdata_a = '0;
      reset_b = 1'b1; req_b = 1'b0; we_b = 1'b0; wstrb_b = '0; addr_b = '0; wdata_b = '0;
      repeat (3) @(posedge clk);
      #1;
      reset_a = 1'b0;
      reset_b = 1'b0;
      @(negedge clk);
      chk("rst_a_ready", {31'd0, ready_a}, 32'd0);
      chk("rst_a_error", {31'd0, error_a}, 32'd0);
      chk("rst_a_busy",  {31'd0, busy_a},  32'd0);
      chk("rst_a_rdata", rdata_a, 32'd0);
      chk("rst_b_ready", {31'd0, ready_b}, 32'd0);
      chk("rst_b_busy",  {31'd0, busy_b},  32'd0);
      @(posedge clk); #1;

      // Full-word store/load, partial store, no-op store.
      acc_a(1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
      acc_a(1'b0, 4'b0000, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF);
      acc_a(1'b1, 4'b0001, 32'h10, 32'h000000AA, 1'b0, 32'h0);
      acc_a(1'b0, 4'b0000, 32'h10, 32'h0,        1'b0, 32'hDEADBEAA);
      acc_a(1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, 1'b0, 32'h0);
      acc_a(1'b0, 4'b0000, 32'h10, 32'h0,        1'b0, 32'hDEADBEAA);

      // Misaligned and out-of-range accesses are rejected and never write.
      acc_a(1'b0, 4'b0000, 32'h12, 32'h0,        1'b1, 32'h0);
      acc_a(1'b1, 4'b1111, 32'h0,  32'h11111111, 1'b0, 32'h0);
      acc_a(1'b1, 4'b1111, 32'h1000, 32'hFFFFFFFF, 1'b1, 32'h0);
      acc_a(1'b1, 4'b1111, 32'h11, 32'hFFFFFFFF, 1'b1, 32'h0);
      acc_a(1'b0, 4'b0000, 32'h0,  32'h0,        1'b0, 32'h11111111);
      acc_a(1'b0, 4'b0000, 32'h10, 32'h0,        1'b0, 32'hDEADBEAA);
      acc_a(1'b0, 4'b0000, 32'h1000, 32'h0,      1'b1, 32'h0);

      // Reset during WAIT drops the store; reset beats a simultaneous request.
      acc_a(1'b1, 4'b1111, 32'h20, 32'hCAFEF00D, 1'b0, 32'h0);
      req_a = 1'b1; we_a = 1'b1; wstrb_a = 4'b1111; addr_a = 32'h20; wdata_a = 32'h12345678;
      @(posedge clk); #1;
      req_a = 1'b0;
      reset_a = 1'b1;
      @(posedge clk); #1;
      reset_a = 1'b0;
      @(negedge clk);
      chk("a_busy_after_mid_reset", {31'd0, busy_a}, 32'd0);
      repeat (WA + 2) @(posedge clk);
      #1;
      reset_a = 1'b1; req_a = 1'b1; we_a = 1'b1; addr_a = 32'h20; wdata_a = 32'hFFFFFFFF;
      @(posedge clk); #1;
      reset_a = 1'b0; req_a = 1'b0;
      @(negedge clk);
      chk("a_busy_reset_with_req", {31'd0, busy_a}, 32'd0);
      @(posedge clk); #1;
      acc_a(1'b0, 4'b0000, 32'h20, 32'h0, 1'b0, 32'hCAFEF00D);

      // Inputs changing during WAIT must not affect the latched access.
      acc_a(1'b1, 4'b1111, 32'h34, 32'h0BADF00D, 1'b0, 32'h0);
      req_a = 1'b1; we_a = 1'b1; wstrb_a = 4'b1111; addr_a = 32'h30; wdata_a = 32'h55AA55AA;
      @(posedge clk); #1;
      q_a.push_back('{1'b0, 32'h0, cyc + WA});
      req_a = 1'b0; we_a = 1'b0; addr_a = 32'h34; wdata_a = 32'h0; wstrb_a = 4'b0000;
      nbusy = 0;
      for (int i = 0; i < WA + 2; i++) begin
         @(negedge clk);
         if (busy_a) nbusy++;
      end
      chk("a_busy_cycles", nbusy, WA + 1);
      @(posedge clk); #1;
      acc_a(1'b0, 4'b0000, 32'h30, 32'h0, 1'b0, 32'h55AA55AA);
      acc_a(1'b0, 4'b0000, 32'h34, 32'h0, 1'b0, 32'h0BADF00D);

      // Zero wait states, req held high: one access every second cycle.
      req_b = 1'b1; we_b = 1'b1; wstrb_b = 4'b1111; addr_b = 32'h0; wdata_b = 32'hA0A0A0A0;
      @(posedge clk); #1;
      a0 = cyc;
      q_b.push_back('{1'b0, 32'h0, a0});
      q_b.push_back('{1'b0, 32'h0, a0 + 2});
      q_b.push_back('{1'b0, 32'h0, a0 + 4});
      addr_b = 32'h4; wdata_b = 32'hB1B1B1B1;
      repeat (2) @(posedge clk);
      #1;
      addr_b = 32'h8; wdata_b = 32'hC2C2C2C2;
      repeat (2) @(posedge clk);
      #1;
      req_b = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      acc_b(1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 32'hA0A0A0A0);
      acc_b(1'b0, 4'b0000, 32'h4, 32'h0, 1'b0, 32'hB1B1B1B1);
      acc_b(1'b0, 4'b0000, 32'h8, 32'h0, 1'b0, 32'hC2C2C2C2);
      acc_b(1'b0, 4'b0000, 32'h6, 32'h0, 1'b1, 32'h0);

      // Every pushed response must have been observed.
      repeat (6) @(posedge clk);
      #1;
      chk("a_missing_responses", q_a.size(), 32'd0);
      chk("b_missing_responses", q_b.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
